fetch_controller: RTL

Fetch-stage sequencer that owns the program counter and drives the address of the combinational instruction memory. It registers the returned instruction into the IF/ID buffer and handles hazard stalls and branch redirects from EX. It also detects the HALT opcode, drains the pipeline, and parks in a halted state until restarted. It sits between the PC/instruction memory pair and the IF/ID buffer.

---
 rtl/fetch_controller.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the PC, registers memory output into IF/ID, handles redirect/stall/HALT drain.
// Latency: 1 cycle fetch-to-IF/ID, 1-bubble branch penalty; halted rises DRAIN_CYCLES edges after HALT lands.
// Backpressure: id_stall freezes PC, IF/ID, fetch count and drain counter; a redirect overrides it.
module fetch_controller #(
   parameter logic [15:0] RESET_PC     = 16'h0000,
   parameter logic [15:0] HALT_OPCODE  = 16'h0000,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] if_from_pc,
   input  logic [15:0] if_instruction,
   input  logic        id_stall,
   input  logic        ex_branch_taken,
   input  logic [15:0] ex_branch_target,
   input  logic        restart,
   output logic [15:0] if_id_instruction,
   output logic [15:0] if_id_pc_plus2,
   output logic        if_id_valid,
   output logic        halted,
   output logic [15:0] if_fetch_count
);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc_plus2;
      logic        valid;
   } if_id_t;

   localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

   state_t      state_q, state_d;
   logic [15:0] pc_q;
   logic [3:0]  drain_q;
   if_id_t      if_id_q;
   logic        halted_q;
   logic [15:0] count_q;

   logic [15:0] pc_plus2;
   logic [15:0] branch_pc;
   logic        is_halt;
   logic        drain_last;
   logic        take_branch;
   logic        take_fetch;
   logic        drain_step;
   logic        take_restart;

   assign pc_plus2   = pc_q + 16'd2;
   assign branch_pc  = {ex_branch_target[15:1], 1'b0};
   assign is_halt    = (if_instruction == HALT_OPCODE);
   assign drain_last = (drain_q <= 4'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (!ex_branch_taken && !id_stall && is_halt) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (ex_branch_taken)              state_d = ST_RUN;
            else if (!id_stall && drain_last) state_d = ST_HALTED;
         end
         ST_HALTED: begin
            if (restart) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // HALTED ignores redirects and stalls; only restart leaves it.
   always_comb begin
      take_branch  = 1'b0;
      take_fetch   = 1'b0;
      drain_step   = 1'b0;
      take_restart = 1'b0;
      case (state_q)
         ST_RUN: begin
            take_branch = ex_branch_taken;
            take_fetch  = !ex_branch_taken && !id_stall;
         end
         ST_DRAIN: begin
            take_branch = ex_branch_taken;
            drain_step  = !ex_branch_taken && !id_stall;
         end
         ST_HALTED: begin
            take_restart = restart;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         drain_q  <= 4'd0;
         if_id_q  <= '0;
         halted_q <= 1'b0;
         count_q  <= 16'd0;
      end else if (take_branch) begin
         pc_q    <= branch_pc;
         if_id_q <= '0;
         drain_q <= 4'd0;
      end else if (take_fetch) begin
         if_id_q <= '{instr: if_instruction, pc_plus2: pc_plus2, valid: 1'b1};
         if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
         // The HALT word is delivered but the PC parks on it.
         if (is_halt) drain_q <= DRAIN_INIT;
         else         pc_q    <= pc_plus2;
      end else if (drain_step) begin
         if_id_q <= '0;
         drain_q <= drain_q - 4'd1;
         if (drain_last) halted_q <= 1'b1;
      end else if (take_restart) begin
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
         count_q  <= 16'd0;
      end
   end

   assign if_from_pc        = pc_q;
   assign if_id_instruction = if_id_q.instr;
   assign if_id_pc_plus2    = if_id_q.pc_plus2;
   assign if_id_valid       = if_id_q.valid;
   assign halted            = halted_q;
   assign if_fetch_count    = count_q;

endmodule
